// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM: steps each instruction through IF/ID/EXE/MEM/WB,
// drives datapath enables and the PC strobe, and counts retired instructions.
module mc_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             InsMemRW,
  output logic             IRWre,
  output logic             ExtSel,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             mRD,
  output logic             mWR,
  output logic             RegWre,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             DBDataSrc,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000, OP_AND = 6'b010001, OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000, OP_SLT = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000, OP_LW  = 6'b110001, OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000, OP_JR  = 6'b111001, OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_rtype, is_alu, is_mem, is_jump;

  assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_OR) ||
                    (opcode == OP_AND) || (opcode == OP_SLL) || (opcode == OP_SLT);
  assign is_alu   = is_rtype || (opcode == OP_ADDI) || (opcode == OP_ORI);
  assign is_mem   = (opcode == OP_SW) || (opcode == OP_LW);
  assign is_jump  = (opcode == OP_J) || (opcode == OP_JR) || (opcode == OP_JAL);

  always_comb begin
    state_d   = state_q;
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    InsMemRW  = 1'b0;
    IRWre     = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    mRD       = 1'b0;
    mWR       = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    halted    = (state_q == S_HALT);

    // IR is still loading during IF, so opcode decodes are held low there
    if (state_q != S_IF) begin
      ExtSel    = (opcode != OP_ORI);
      ALUSrcA   = (opcode == OP_SLL);
      ALUSrcB   = (opcode == OP_ADDI) || (opcode == OP_ORI) || is_mem;
      DBDataSrc = (opcode == OP_LW);
      unique case (opcode)
        OP_SUB, OP_BEQ: ALUOp = 3'b001;
        OP_SLL:         ALUOp = 3'b010;
        OP_OR, OP_ORI:  ALUOp = 3'b011;
        OP_AND:         ALUOp = 3'b100;
        OP_SLT:         ALUOp = 3'b110;
        default:        ALUOp = 3'b000;
      endcase
      if (is_rtype)                                                    RegDst = 2'b10;
      else if ((opcode == OP_ADDI) || (opcode == OP_ORI) || (opcode == OP_LW)) RegDst = 2'b01;
    end

    unique case (state_q)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        if (is_jump) begin
          PCWre   = 1'b1;
          PCSrc   = (opcode == OP_JR) ? 2'b10 : 2'b11;
          RegWre  = (opcode == OP_JAL);
          state_d = S_IF;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (is_alu || is_mem || (opcode == OP_BEQ)) begin
          state_d = S_EXE;
        end else begin
          PCWre   = 1'b1;
          state_d = S_IF;
        end
      end
      S_EXE: begin
        if (opcode == OP_BEQ) begin
          PCWre   = 1'b1;
          PCSrc   = {1'b0, zero};
          state_d = S_IF;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else if (is_alu) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        if (opcode == OP_SW) begin
          mWR     = 1'b1;
          PCWre   = 1'b1;
          state_d = S_IF;
        end else if (opcode == OP_LW) begin
          mRD     = 1'b1;
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB: begin
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
        state_d   = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    // no strobe may escape during a reset cycle, even mid-instruction
    if (!reset) begin
      PCWre     = 1'b0;
      PCSrc     = 2'b00;
      InsMemRW  = 1'b0;
      IRWre     = 1'b0;
      ExtSel    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'b000;
      mRD       = 1'b0;
      mWR       = 1'b0;
      RegWre    = 1'b0;
      RegDst    = 2'b00;
      WrRegDSrc = 1'b0;
      DBDataSrc = 1'b0;
      halted    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (PCWre) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule
